histogram_stream: RTL and testbench

- Parametrised successor to the single-configuration histogram core; sits behind the top-level pin wrapper.
- Bins incoming samples into NUM_BINS saturating counters, then streams the bins out on a valid/ready interface.
- Each bin is cleared as it is read out.
- Adds configurable width/depth, output backpressure, a saturation flag and an auto-clear sequence.

---
 rtl/histogram_stream_if.sv | 42 ++++
 rtl/histogram_stream.sv | 152 +++++++++++++++
 tb/tb_histogram_stream.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/histogram_stream_if.sv
// Sample/readout bundle for histogram_stream: sample strobe in, bin beats out (valid/ready).
// Peak-tracking signals exist only when HISTOGRAM_PEAK_EN is defined.
interface histogram_stream_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_BINS = 16,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned BIN_W = $clog2(NUM_BINS);

    logic [DATA_W-1:0] data_in;
    logic              write_en;
    logic              read_start;
    logic              ready;
    logic [CNT_W-1:0]  data_out;
    logic [BIN_W-1:0]  bin_idx;
    logic              valid_out;
    logic              out_ready;
    logic              last_bin;
    logic              sat_flag;
`ifdef HISTOGRAM_PEAK_EN
    logic [BIN_W-1:0]  peak_bin;
    logic [CNT_W-1:0]  peak_cnt;

    modport master (
        output data_in, write_en, read_start, out_ready,
        input  ready, data_out, bin_idx, valid_out, last_bin, sat_flag, peak_bin, peak_cnt
    );
    modport slave (
        input  data_in, write_en, read_start, out_ready,
        output ready, data_out, bin_idx, valid_out, last_bin, sat_flag, peak_bin, peak_cnt
    );
`else
    modport master (
        output data_in, write_en, read_start, out_ready,
        input  ready, data_out, bin_idx, valid_out, last_bin, sat_flag
    );
    modport slave (
        input  data_in, write_en, read_start, out_ready,
        output ready, data_out, bin_idx, valid_out, last_bin, sat_flag
    );
`endif
endinterface

// File: rtl/histogram_stream.sv
// Streaming histogram: saturating per-bin counters, cleared-on-read valid/ready readout.
// Optional peak tracker enabled by defining HISTOGRAM_PEAK_EN.
module histogram_stream #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_BINS = 16,
    parameter int unsigned CNT_W    = 8
) (
    input logic               clk,
    input logic               rst_n,
    histogram_stream_if.slave bus
);
    localparam int unsigned BIN_W = $clog2(NUM_BINS);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [BIN_W-1:0] LastIdx = BIN_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {StClear, StAccum, StDrain, StRead} state_e;

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [BIN_W-1:0]  s1_idx_q, s1_idx_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  cnt_q [NUM_BINS];

    logic              cnt_we;
    logic [BIN_W-1:0]  cnt_waddr;
    logic [CNT_W-1:0]  cnt_wdata;
    logic [CNT_W-1:0]  s2_cur;
    logic              s2_full;
    logic              valid;
    logic              final_beat;
    logic              unused_data;

    // Stage 2 reads the live counter array, so back-to-back hits see the previous increment.
    assign s2_cur      = cnt_q[s1_idx_q];
    assign s2_full     = (s2_cur == CntMax);
    assign valid       = (state_q == StRead);
    assign final_beat  = valid && bus.out_ready && (ptr_q == LastIdx);
    assign unused_data = ^bus.data_in;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        s1_valid_d = 1'b0;
        s1_idx_d   = s1_idx_q;
        sat_d      = sat_q;
        cnt_we     = 1'b0;
        cnt_waddr  = s1_idx_q;
        cnt_wdata  = '0;

        if (s1_valid_q) begin
            cnt_we    = 1'b1;
            cnt_wdata = s2_full ? s2_cur : s2_cur + 1'b1;
            if (s2_full) sat_d = 1'b1;
        end

        unique case (state_q)
            StClear: begin
                cnt_we    = 1'b1;
                cnt_waddr = ptr_q;
                cnt_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LastIdx) state_d = StAccum;
            end
            StAccum: begin
                if (bus.read_start) begin
                    state_d = StDrain;
                end else if (bus.write_en) begin
                    s1_valid_d = 1'b1;
                    s1_idx_d   = bus.data_in[DATA_W-1 -: BIN_W];
                end
            end
            StDrain: begin
                state_d = StRead;
                ptr_d   = '0;
            end
            StRead: begin
                if (bus.out_ready) begin
                    cnt_we    = 1'b1;
                    cnt_waddr = ptr_q;
                    cnt_wdata = '0;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == LastIdx) begin
                        state_d = StAccum;
                        sat_d   = 1'b0;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            sat_q      <= sat_d;
        end
    end

    // Counter storage is initialised by the CLEAR sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (cnt_we) cnt_q[cnt_waddr] <= cnt_wdata;
    end

    assign bus.ready     = (state_q == StAccum);
    assign bus.valid_out = valid;
    assign bus.bin_idx   = valid ? ptr_q : '0;
    assign bus.data_out  = valid ? cnt_q[ptr_q] : '0;
    assign bus.last_bin  = valid && (ptr_q == LastIdx);
    assign bus.sat_flag  = sat_q;

`ifdef HISTOGRAM_PEAK_EN
    logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
    logic [CNT_W-1:0] peak_cnt_q, peak_cnt_d;

    // Strict compare keeps the earliest bin on ties; commits during DRAIN leave peak frozen.
    always_comb begin
        peak_bin_d = peak_bin_q;
        peak_cnt_d = peak_cnt_q;
        if ((state_q == StAccum) && s1_valid_q && (cnt_wdata > peak_cnt_q)) begin
            peak_bin_d = s1_idx_q;
            peak_cnt_d = cnt_wdata;
        end
        if (final_beat) begin
            peak_bin_d = '0;
            peak_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_bin_q <= '0;
            peak_cnt_q <= '0;
        end else begin
            peak_bin_q <= peak_bin_d;
            peak_cnt_q <= peak_cnt_d;
        end
    end

    assign bus.peak_bin = peak_bin_q;
    assign bus.peak_cnt = peak_cnt_q;
`endif
endmodule

// File: tb/tb_histogram_stream.sv
// Directed bench for histogram_stream: clear timing, binning, saturation, stalls,
// read_start priority and reset during readout.
module tb_histogram_stream;
    localparam int unsigned DW = 16;
    localparam int unsigned NB = 16;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    histogram_stream_if #(.DATA_W(DW), .NUM_BINS(NB), .CNT_W(CW)) bus ();

    histogram_stream #(.DATA_W(DW), .NUM_BINS(NB), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [DW-1:0] d);
        bus.write_en = 1'b1;
        bus.data_in  = d;
        step();
        bus.write_en = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < NB; i++) begin
            chk({tag, ":ready_lo"}, int'(bus.ready), 0);
            step();
        end
        chk({tag, ":ready_hi"}, int'(bus.ready), 1);
    endtask

    task automatic readout(input int exp_b[NB], input bit stall, input string tag);
        bit pat [4];
        int idx;
        int cyc;
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.read_start = 1'b1;
        step();
        bus.read_start = 1'b0;
        bus.write_en   = 1'b0;
        chk({tag, ":ready_drop"}, int'(bus.ready), 0);
        cyc = 0;
        while (!bus.valid_out && cyc < 8) begin
            step();
            cyc++;
        end
        chk({tag, ":valid_up"}, int'(bus.valid_out), 1);
        idx = 0;
        k   = 0;
        cyc = 0;
        while (idx < NB && cyc < 200 && bus.valid_out) begin
            bus.out_ready = stall ? pat[k % 4] : 1'b1;
            k++;
            chk({tag, ":bin_idx"}, int'(bus.bin_idx), idx);
            chk({tag, ":data"}, int'(bus.data_out), exp_b[idx]);
            chk({tag, ":last"}, int'(bus.last_bin), int'(idx == NB - 1));
            if (bus.out_ready) idx++;
            step();
            cyc++;
        end
        bus.out_ready = 1'b1;
        chk({tag, ":beats"}, idx, NB);
        chk({tag, ":valid_end"}, int'(bus.valid_out), 0);
        chk({tag, ":ready_back"}, int'(bus.ready), 1);
    endtask

    initial begin
        int e[NB];
        int cyc;
        bus.data_in    = '0;
        bus.write_en   = 1'b0;
        bus.read_start = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset state
        #1;
        chk("rst:ready", int'(bus.ready), 0);
        chk("rst:valid", int'(bus.valid_out), 0);
        chk("rst:last", int'(bus.last_bin), 0);
        chk("rst:data", int'(bus.data_out), 0);
        chk("rst:idx", int'(bus.bin_idx), 0);
        chk("rst:sat", int'(bus.sat_flag), 0);
`ifdef HISTOGRAM_PEAK_EN
        chk("rst:peak_bin", int'(bus.peak_bin), 0);
        chk("rst:peak_cnt", int'(bus.peak_cnt), 0);
`endif
        step();
        step();
        rst_n = 1'b1;
        wait_clear("boot");

        e = '{default: 0};
        readout(e, 1'b0, "empty");

        // Basic binning: top nibble selects the bin
        sample(16'h1234);
        sample(16'h1FFF);
        sample(16'hF000);
        sample(16'h1000);
        step();
        chk("basic:sat", int'(bus.sat_flag), 0);
`ifdef HISTOGRAM_PEAK_EN
        chk("basic:peak_bin", int'(bus.peak_bin), 1);
        chk("basic:peak_cnt", int'(bus.peak_cnt), 3);
`endif
        e = '{default: 0};
        e[1]  = 3;
        e[15] = 1;
        readout(e, 1'b0, "basic");
`ifdef HISTOGRAM_PEAK_EN
        chk("basic:peak_clr", int'(bus.peak_cnt), 0);
`endif

        // Saturation: 300 hits on bin 5
        bus.data_in  = 16'h5000;
        bus.write_en = 1'b1;
        repeat (300) step();
        bus.write_en = 1'b0;
        step();
        chk("sat:flag_set", int'(bus.sat_flag), 1);
`ifdef HISTOGRAM_PEAK_EN
        chk("sat:peak_bin", int'(bus.peak_bin), 5);
        chk("sat:peak_cnt", int'(bus.peak_cnt), 255);
`endif
        e = '{default: 0};
        e[5] = 255;
        readout(e, 1'b0, "sat");
        chk("sat:flag_clr", int'(bus.sat_flag), 0);
        e = '{default: 0};
        readout(e, 1'b0, "sat_again");
        chk("sat_again:flag", int'(bus.sat_flag), 0);

        // Backpressure: out_ready pattern 1,0,0,1
        sample(16'h0000);
        sample(16'h7000);
        sample(16'h7ABC);
        step();
        e = '{default: 0};
        e[0] = 1;
        e[7] = 2;
        readout(e, 1'b1, "stall");

        // read_start wins over a same-cycle write; in-flight stage-1 sample still lands
        bus.write_en = 1'b1;
        bus.data_in  = 16'h2000;
        step();
        bus.data_in  = 16'h3000;
        e = '{default: 0};
        e[2] = 1;
        readout(e, 1'b0, "prio");

        // Reset asserted mid-readout at bin 7
        sample(16'h7000);
        sample(16'h7000);
        step();
        bus.read_start = 1'b1;
        step();
        bus.read_start = 1'b0;
        cyc = 0;
        while ((!bus.valid_out || bus.bin_idx != 4'd7) && cyc < 40) begin
            step();
            cyc++;
        end
        chk("abort:at_bin7", int'(bus.bin_idx), 7);
        chk("abort:data7", int'(bus.data_out), 2);
        rst_n = 1'b0;
        #1;
        chk("abort:valid", int'(bus.valid_out), 0);
        chk("abort:ready", int'(bus.ready), 0);
        chk("abort:idx", int'(bus.bin_idx), 0);
        chk("abort:data", int'(bus.data_out), 0);
`ifdef HISTOGRAM_PEAK_EN
        chk("abort:peak_bin", int'(bus.peak_bin), 0);
        chk("abort:peak_cnt", int'(bus.peak_cnt), 0);
`endif
        step();
        rst_n = 1'b1;
        wait_clear("reclear");
        e = '{default: 0};
        readout(e, 1'b0, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
